register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 58 +++++
 tb/tb_register_file.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module      : register_file
// Description : 32 x 32-bit register file with two asynchronous read ports
//               and one synchronous write port. Register 0 is hardwired to
//               zero. Synchronous active-high reset clears all registers.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] a1,
    input  logic [ADDR_W-1:0] a2,
    input  logic [ADDR_W-1:0] a3,
    input  logic [DATA_W-1:0] wd3,
    input  logic              we,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];

    // Next-state: single write port; entry 0 is forced to zero so a write to
    // address 0 is silently dropped and the entry never holds anything else.
    always_comb begin
        regs_d = regs_q;
        if (we && (a3 != '0)) begin
            regs_d[a3] = wd3;
        end
        regs_d[0] = '0;
    end

    // Storage update: reset wins over any write requested in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Asynchronous reads straight from storage (no write-through bypass);
    // address 0 decodes to a constant zero independent of storage.
    always_comb begin
        rd1 = (a1 == '0) ? '0 : regs_q[a1];
        rd2 = (a2 == '0) ? '0 : regs_q[a2];
    end

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file
// Description : Self-checking bench for register_file: directed scenarios
//               followed by randomized traffic against an array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file;

    logic        clk;
    logic        reset;
    logic [4:0]  a1, a2, a3;
    logic [31:0] wd3;
    logic        we;
    logic [31:0] rd1, rd2;

    int n_checks = 0;
    int n_errors = 0;

    // Reference storage: plain array of 32 words, entry 0 always reads zero.
    logic [31:0] model [32];

    register_file #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk  (clk),
        .reset(reset),
        .a1   (a1),
        .a2   (a2),
        .a3   (a3),
        .wd3  (wd3),
        .we   (we),
        .rd1  (rd1),
        .rd2  (rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [4:0] a);
        return (a == 5'd0) ? 32'h0 : model[a];
    endfunction

    // Compare both read ports to the model for the current addresses.
    task automatic check_reads(input string tag);
        #1;
        check({tag, "_rd1"}, rd1, model_rd(a1));
        check({tag, "_rd2"}, rd2, model_rd(a2));
    endtask

    // One clock edge with the given controls; the model follows the rules:
    // reset clears everything, else a write with we lands unless a3 is 0.
    task automatic cycle(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] d);
        reset = r; we = w; a3 = wa; wd3 = d;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (w && wa != 5'd0) begin
            model[wa] = d;
        end
        #1;
        reset = 1'b0; we = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        reset = 1'b1; we = 1'b0; a1 = '0; a2 = '0; a3 = '0; wd3 = '0;

        // Reset for one edge, then every address must read zero.
        cycle(1'b1, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 32; i++) begin
            a1 = 5'(i); a2 = 5'(31 - i);
            #1;
            check("reset_sweep_rd1", rd1, 32'h0);
            check("reset_sweep_rd2", rd2, 32'h0);
        end

        // Write i to register i, read back on both ports.
        for (int i = 1; i < 32; i++) begin
            cycle(1'b0, 1'b1, 5'(i), 32'(i));
            a1 = 5'(i); a2 = 5'(i);
            #1;
            check("wr_idx_rd1", rd1, 32'(i));
            check("wr_idx_rd2", rd2, 32'(i));
        end

        // Writes to register 0 are discarded.
        cycle(1'b0, 1'b1, 5'd0, 32'hDEADBEEF);
        a1 = 5'd0; a2 = 5'd0;
        #1;
        check("r0_rd1", rd1, 32'h0);
        check("r0_rd2", rd2, 32'h0);

        // we=0 leaves storage untouched.
        cycle(1'b0, 1'b1, 5'd7, 32'hA5A5A5A5);
        cycle(1'b0, 1'b0, 5'd7, 32'h12345678);
        a1 = 5'd7;
        #1;
        check("we0_hold", rd1, 32'hA5A5A5A5);

        // Two ports independent; no bypass before the write edge.
        cycle(1'b0, 1'b1, 5'd3, 32'd3);
        a1 = 5'd3; a2 = 5'd9;
        reset = 1'b0; we = 1'b1; a3 = 5'd9; wd3 = 32'd9009;
        #1;
        check("pre_edge_rd2_old", rd2, 32'd9);
        check("pre_edge_rd1", rd1, 32'd3);
        cycle(1'b0, 1'b1, 5'd9, 32'd9009);
        check("post_edge_rd2_new", rd2, 32'd9009);
        check("post_edge_rd1", rd1, 32'd3);
        cycle(1'b0, 1'b1, 5'd9, 32'd9);
        #1;
        check("dual_rd1", rd1, 32'd3);
        check("dual_rd2", rd2, 32'd9);

        // Reset beats a concurrent write.
        cycle(1'b0, 1'b1, 5'd5, 32'd55);
        a1 = 5'd5;
        #1;
        check("pre_reset_r5", rd1, 32'd55);
        cycle(1'b1, 1'b1, 5'd5, 32'd77);
        check("reset_prio_r5", rd1, 32'h0);
        a1 = 5'd7;
        #1;
        check("reset_clears_r7", rd1, 32'h0);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            logic       r, w;
            logic [4:0] wa;
            logic [31:0] d;
            r  = ($urandom_range(0, 39) == 0);
            w  = ($urandom_range(0, 3) != 0);
            wa = 5'($urandom_range(0, 31));
            d  = $urandom;
            a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 7) == 0) ? a1 : 5'($urandom_range(0, 31));
            reset = r; we = w; a3 = wa; wd3 = d;
            check_reads("rnd_pre");
            cycle(r, w, wa, d);
            check_reads("rnd_post");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
